// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR stage: holds mstatus.MIE/MPIE, mtvec, mepc, mcause, mscratch,
// services CSR read/modify/write and issues a registered one-cycle PC redirect on traps and mret.
module trap_csr_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ecall,
  input  logic            i_mret,
  input  logic            i_illegal,
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_csrOp,
  input  logic [11:0]     i_csrAddr,
  input  logic [XLEN-1:0] i_csrWdata,
  output logic [XLEN-1:0] o_csrRdata,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirectPc,
  output logic            o_mie
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(4'd2);
  localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(4'd11);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0] rdata_s;
  logic [XLEN-1:0] csr_new_s;

  // Old-value read mux; unmapped addresses and unimplemented mstatus bits read zero
  always_comb begin
    rdata_s = '0;
    case (i_csrAddr)
      ADDR_MSTATUS: begin
        rdata_s[3]     = mie_q;
        rdata_s[7]     = mpie_q;
        rdata_s[12:11] = 2'b11;
      end
      ADDR_MTVEC:    rdata_s = mtvec_q;
      ADDR_MSCRATCH: rdata_s = mscratch_q;
      ADDR_MEPC:     rdata_s = {mepc_q[XLEN-1:2], 2'b00};
      ADDR_MCAUSE:   rdata_s = mcause_q;
      default:       rdata_s = '0;
    endcase
  end

  // Read-modify-write value for RW/RS/RC
  always_comb begin
    csr_new_s = rdata_s;
    case (i_csrOp)
      2'b01:   csr_new_s = i_csrWdata;
      2'b10:   csr_new_s = rdata_s | i_csrWdata;
      2'b11:   csr_new_s = rdata_s & ~i_csrWdata;
      default: csr_new_s = rdata_s;
    endcase
  end

  // Trap/mret sequencing and CSR writes; trap events win over a same-cycle CSR write
  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (i_illegal || i_ecall) begin
          mepc_d        = i_pc;
          mcause_d      = i_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL_M;
          mpie_d        = mie_q;
          mie_d         = 1'b0;
          redirect_d    = 1'b1;
          redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
          state_d       = FLUSH;
        end else if (i_mret) begin
          mie_d         = mpie_q;
          mpie_d        = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = {mepc_q[XLEN-1:2], 2'b00};
          state_d       = FLUSH;
        end else if (i_csrOp != 2'b00) begin
          case (i_csrAddr)
            ADDR_MSTATUS: begin
              mie_d  = csr_new_s[3];
              mpie_d = csr_new_s[7];
            end
            ADDR_MTVEC:    mtvec_d    = {csr_new_s[XLEN-1:2], 2'b00};
            ADDR_MSCRATCH: mscratch_d = csr_new_s;
            ADDR_MEPC:     mepc_d     = csr_new_s;
            ADDR_MCAUSE:   mcause_d   = csr_new_s;
            default:       mscratch_d = mscratch_q;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      // Flushed slot: the instruction here never retires
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mepc_q        <= '0;
      mcause_q      <= '0;
      mscratch_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_csrRdata   = rdata_s;
  assign o_redirect   = redirect_q;
  assign o_redirectPc = redirect_pc_q;
  assign o_mie        = mie_q;

endmodule
